// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and defaults for the N-core data-memory arbiter.
// Optional watchdog feature is enabled by defining CORE_ARB_TIMEOUT_EN.
package core_mem_arbiter_pkg;

  localparam int ARB_RW          = 16;
  localparam int ARB_ADDR_BYTES  = 2;
  localparam int ARB_TIMEOUT_DEF = 255;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_arb_rr_pick.sv
// Combinational round-robin picker: first unmasked requester after ptr,
// wrapping modulo CORES.
module core_arb_rr_pick
  import core_mem_arbiter_pkg::*;
#(
  parameter int CORES = 2,
  localparam int IW   = idx_w(CORES)
) (
  input  logic [CORES-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic [CORES-1:0] mask,
  output logic             valid,
  output logic [IW-1:0]    win
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    valid = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 1; i <= CORES; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(CORES)) sum = sum - (IW+1)'(CORES);
      idx = sum[IW-1:0];
      if (!valid && req[idx] && !mask[idx]) begin
        valid = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory bus among CORES core ports.
// Define CORE_ARB_TIMEOUT_EN to abort transfers that see no ack in TIMEOUT cycles.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int CORES   = 2,
  parameter int RW      = ARB_RW,
  parameter int SEL_W   = ARB_ADDR_BYTES,
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [CORES-1:0]      i_c_mem_req,
  input  logic [CORES-1:0]      i_c_mem_we,
  input  logic [CORES*RW-1:0]   i_c_mem_addr,
  input  logic [CORES*RW-1:0]   i_c_mem_data,
  input  logic [CORES*SEL_W-1:0] i_c_mem_sel,
  output logic [CORES-1:0]      o_c_mem_ack,
  output logic [RW-1:0]         o_c_mem_data,
  output logic [CORES-1:0]      o_c_mem_exception,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [RW-1:0]         o_mem_addr,
  output logic [RW-1:0]         o_mem_data,
  output logic [SEL_W-1:0]      o_mem_sel,
  input  logic [RW-1:0]         i_mem_data,
  input  logic                  i_mem_ack,
  input  logic                  i_mem_err
);

  localparam int IW = idx_w(CORES);

  arb_state_e state, state_nx;
  logic [IW-1:0]    grant, ptr;
  logic [CORES-1:0] grant_oh;
  logic             busy, tmo_hit, done, load;
  logic             pick_valid;
  logic [IW-1:0]    pick_win, pick_ptr;
  logic [CORES-1:0] pick_mask;

  logic [CORES-1:0][RW-1:0]    c_addr, c_data;
  logic [CORES-1:0][SEL_W-1:0] c_sel;

  assign c_addr = i_c_mem_addr;
  assign c_data = i_c_mem_data;
  assign c_sel  = i_c_mem_sel;

  assign busy     = (state == ARB_BUSY);
  assign grant_oh = CORES'(1) << grant;

`ifdef CORE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  // Watchdog fires only when no real ack arrives in the same cycle.
  assign tmo_hit = busy && !i_mem_ack && (cnt == CW'(TIMEOUT));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)        cnt <= '0;
    else if (load)     cnt <= '0;
    else if (busy && !done) cnt <= cnt + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT != 0);
  assign tmo_hit    = 1'b0;
`endif

  assign done = busy && (i_mem_ack || tmo_hit);

  // One picker serves both the idle grant and the ack-cycle re-grant; the
  // finishing core is masked because its req is still high that cycle.
  assign pick_ptr  = busy ? grant : ptr;
  assign pick_mask = busy ? grant_oh : '0;

  core_arb_rr_pick #(.CORES(CORES)) u_pick (
    .req   (i_c_mem_req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .valid (pick_valid),
    .win   (pick_win)
  );

  assign load = pick_valid && (!busy || done);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ARB_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE: if (pick_valid) state_nx = ARB_BUSY;
      ARB_BUSY: if (done)       state_nx = pick_valid ? ARB_BUSY : ARB_IDLE;
      default:                  state_nx = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_c_mem_ack       = '0;
    o_c_mem_exception = '0;
    o_c_mem_data      = i_mem_data;
    if (done) begin
      o_c_mem_ack       = grant_oh;
      o_c_mem_exception = grant_oh & {CORES{(i_mem_ack && i_mem_err) || tmo_hit}};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      grant      <= '0;
      ptr        <= IW'(CORES - 1);
      o_mem_req  <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_mem_sel  <= '0;
    end else begin
      if (done) ptr <= grant;
      if (load) begin
        grant      <= pick_win;
        o_mem_req  <= 1'b1;
        o_mem_we   <= i_c_mem_we[pick_win];
        o_mem_addr <= c_addr[pick_win];
        o_mem_data <= c_data[pick_win];
        o_mem_sel  <= c_sel[pick_win];
      end else if (done) begin
        o_mem_req  <= 1'b0;
        o_mem_we   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed scoreboard bench for core_mem_arbiter (CORES=4); also covers the
// CORE_ARB_TIMEOUT_EN build when that macro is defined.
module tb_core_mem_arbiter;

  localparam int CORES   = 4;
  localparam int RW      = 16;
  localparam int SEL_W   = 2;
  localparam int TIMEOUT = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic [CORES-1:0]       i_c_mem_req  = '0;
  logic [CORES-1:0]       i_c_mem_we   = '0;
  logic [CORES*RW-1:0]    i_c_mem_addr = '0;
  logic [CORES*RW-1:0]    i_c_mem_data = '0;
  logic [CORES*SEL_W-1:0] i_c_mem_sel  = '0;
  logic [CORES-1:0]       o_c_mem_ack, o_c_mem_exception;
  logic [RW-1:0]          o_c_mem_data;
  logic                   o_mem_req, o_mem_we;
  logic [RW-1:0]          o_mem_addr, o_mem_data;
  logic [SEL_W-1:0]       o_mem_sel;
  logic [RW-1:0]          i_mem_data = '0;
  logic                   i_mem_ack  = 1'b0;
  logic                   i_mem_err  = 1'b0;

  always #5 i_clk = ~i_clk;

  core_mem_arbiter #(.CORES(CORES), .RW(RW), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_c_mem_req       (i_c_mem_req),
    .i_c_mem_we        (i_c_mem_we),
    .i_c_mem_addr      (i_c_mem_addr),
    .i_c_mem_data      (i_c_mem_data),
    .i_c_mem_sel       (i_c_mem_sel),
    .o_c_mem_ack       (o_c_mem_ack),
    .o_c_mem_data      (o_c_mem_data),
    .o_c_mem_exception (o_c_mem_exception),
    .o_mem_req         (o_mem_req),
    .o_mem_we          (o_mem_we),
    .o_mem_addr        (o_mem_addr),
    .o_mem_data        (o_mem_data),
    .o_mem_sel         (o_mem_sel),
    .i_mem_data        (i_mem_data),
    .i_mem_ack         (i_mem_ack),
    .i_mem_err         (i_mem_err)
  );

  typedef struct {
    int               core;
    logic             we;
    logic [RW-1:0]    addr;
    logic [RW-1:0]    data;
    logic [SEL_W-1:0] sel;
  } sb_t;

  sb_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic core_req(input int c, input logic we, input logic [RW-1:0] addr,
                          input logic [RW-1:0] data, input logic [SEL_W-1:0] sel);
    sb_t e;
    i_c_mem_req[c]                 = 1'b1;
    i_c_mem_we[c]                  = we;
    i_c_mem_addr[c*RW +: RW]       = addr;
    i_c_mem_data[c*RW +: RW]       = data;
    i_c_mem_sel[c*SEL_W +: SEL_W]  = sel;
    e.core = c; e.we = we; e.addr = addr; e.data = data; e.sel = sel;
    sb.push_back(e);
  endtask

  // Downstream responder: checks the registered request against the next
  // scoreboard entry, acks after 'delay' cycles and checks the core-side return.
  task automatic serve(input int delay, input logic [RW-1:0] rd, input logic err);
    sb_t e;
    int  w;
    logic [CORES-1:0] oh;
    w = 0;
    while (!o_mem_req && w < 20) begin tick(); w++; end
    chk("req_seen", {31'b0, o_mem_req}, 32'd1);
    if (sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL sb_underflow observed=empty expected=entry");
      return;
    end
    e  = sb.pop_front();
    oh = CORES'(1) << e.core;
    chk("mem_addr", {16'b0, o_mem_addr}, {16'b0, e.addr});
    chk("mem_we",   {31'b0, o_mem_we},   {31'b0, e.we});
    chk("mem_sel",  {30'b0, o_mem_sel},  {30'b0, e.sel});
    if (e.we) chk("mem_wdata", {16'b0, o_mem_data}, {16'b0, e.data});
    repeat (delay) begin
      chk("hold_req", {31'b0, o_mem_req}, 32'd1);
      chk("no_early_ack", {28'b0, o_c_mem_ack}, 32'd0);
      tick();
    end
    i_mem_ack = 1'b1; i_mem_data = rd; i_mem_err = err;
    #1;
    chk("core_ack",  {28'b0, o_c_mem_ack}, {28'b0, oh});
    chk("core_exc",  {28'b0, o_c_mem_exception}, err ? {28'b0, oh} : 32'd0);
    chk("core_rdata", {16'b0, o_c_mem_data}, {16'b0, rd});
    tick();
    i_mem_ack = 1'b0; i_mem_err = 1'b0;
    i_c_mem_req[e.core] = 1'b0;
    #1;
  endtask

  initial begin
    sb_t tmp;
    int  hi;

    // Reset state
    tick(); tick();
    chk("rst_req",  {31'b0, o_mem_req}, 32'd0);
    chk("rst_we",   {31'b0, o_mem_we},  32'd0);
    chk("rst_addr", {16'b0, o_mem_addr}, 32'd0);
    chk("rst_data", {16'b0, o_mem_data}, 32'd0);
    chk("rst_sel",  {30'b0, o_mem_sel},  32'd0);
    chk("rst_ack",  {28'b0, o_c_mem_ack}, 32'd0);
    chk("rst_exc",  {28'b0, o_c_mem_exception}, 32'd0);
    i_rst = 1'b1;
    tick();

    // Single core-0 read, ack 3 cycles after grant; core-side change ignored
    core_req(0, 1'b0, 16'h1234, 16'h0000, 2'b11);
    tick();
    chk("grant_latency", {31'b0, o_mem_req}, 32'd1);
    i_c_mem_addr[0 +: RW] = 16'h5555;
    serve(3, 16'hBEEF, 1'b0);
    chk("idle_after_read", {31'b0, o_mem_req}, 32'd0);

    // Core 1 write with partial select
    core_req(1, 1'b1, 16'h0040, 16'h00FF, 2'b01);
    tick();
    serve(1, 16'h0000, 1'b0);
    chk("idle_after_write", {31'b0, o_mem_req}, 32'd0);

    // Downstream error on core 1 -> one-cycle exception
    core_req(1, 1'b0, 16'h0080, 16'h0000, 2'b11);
    tick();
    serve(2, 16'h1111, 1'b1);
    chk("exc_one_cycle", {28'b0, o_c_mem_exception}, 32'd0);

    // Reset mid-transfer aborts immediately, no ack to anyone
    core_req(2, 1'b0, 16'h00A0, 16'h0000, 2'b11);
    tick();
    chk("busy_before_rst", {31'b0, o_mem_req}, 32'd1);
    tmp = sb.pop_front();
    #2;
    i_rst = 1'b0;
    #1;
    chk("rst_async_req", {31'b0, o_mem_req}, 32'd0);
    i_mem_ack = 1'b1;
    #1;
    chk("rst_no_ack", {28'b0, o_c_mem_ack}, 32'd0);
    i_mem_ack = 1'b0;
    i_c_mem_req = '0;
    tick(); tick();
    i_rst = 1'b1;
    tick();

    // All four request: served 0,1,2,3 with no bubble
    for (int c = 0; c < CORES; c++)
      core_req(c, 1'b0, 16'h0100 + 16'(c), 16'h0000, 2'b11);
    tick();
    for (int c = 0; c < CORES; c++) begin
      chk("no_bubble", {31'b0, o_mem_req}, 32'd1);
      serve(1, 16'hA000 + 16'(c), 1'b0);
    end
    chk("idle_after_rr", {31'b0, o_mem_req}, 32'd0);

    // No downstream ack
    core_req(3, 1'b0, 16'h0300, 16'h0000, 2'b11);
    tick();
    chk("tmo_grant", {31'b0, o_mem_req}, 32'd1);
`ifdef CORE_ARB_TIMEOUT_EN
    tmp = sb.pop_front();
    for (int k = 0; k < TIMEOUT; k++) begin
      chk("tmo_wait_ack", {28'b0, o_c_mem_ack}, 32'd0);
      tick();
    end
    chk("tmo_ack", {28'b0, o_c_mem_ack}, 32'h8);
    chk("tmo_exc", {28'b0, o_c_mem_exception}, 32'h8);
    tick();
    i_c_mem_req[3] = 1'b0;
    #1;
    chk("tmo_req_drop", {31'b0, o_mem_req}, 32'd0);
    chk("tmo_ack_clear", {28'b0, o_c_mem_ack}, 32'd0);
`else
    hi = 0;
    repeat (100) begin
      if (o_mem_req) hi++;
      tick();
    end
    chk("no_timeout", 32'(hi), 32'd100);
    serve(0, 16'h3333, 1'b0);
    chk("idle_after_long", {31'b0, o_mem_req}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
